// File: rtl/sd_spi_responder_pkg.sv
// Shared definitions for the SD SPI-mode command responder: command indices,
// R1 bit positions, FSM state type and the CRC7 helper used when the
// SD_RESP_CRC_CHECK_EN build option is enabled.
package sd_spi_responder_pkg;

   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD41 = 6'd41;
   localparam logic [5:0] CMD55 = 6'd55;

   localparam int unsigned R1_IDLE_BIT    = 0;
   localparam int unsigned R1_ILLEGAL_BIT = 2;
   localparam int unsigned R1_CRC_BIT     = 3;

   // x^7 + x^3 + 1, x^7 term implicit
   localparam logic [6:0] CRC7_POLY = 7'h09;

   typedef enum logic [1:0] {
      StHunt,
      StCollect,
      StNcr,
      StR1
   } resp_state_e;

   // CRC7 over a 40-bit command body (index byte plus four argument bytes), init 0
   function automatic logic [6:0] crc7(input logic [39:0] data);
      logic [6:0] crc;
      logic       fb;
      crc = '0;
      for (int i = 39; i >= 0; i--) begin
         fb  = data[i] ^ crc[6];
         crc = {crc[5:0], 1'b0};
         if (fb) begin
            crc = crc ^ CRC7_POLY;
         end
      end
      return crc;
   endfunction

endpackage

// File: rtl/sd_spi_responder_spi_slave_byte.sv
// SPI mode-0 byte engine: synchronizes SCLK/MOSI/CS into CLK, detects SCLK
// edges, shifts bytes in on rising edges and out on falling edges. The next
// byte to send is taken from tx_byte at the byte boundary, so the consumer
// must update tx_byte within a cycle or two of byte_done.
module spi_slave_byte
   import sd_spi_responder_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       SCLK,
   input  logic       MOSI,
   input  logic       CS,
   input  logic [7:0] tx_byte,
   output logic       MISO,
   output logic       cs_active,
   output logic       byte_done,
   output logic [7:0] rx_byte
);

   logic [1:0] sclk_sync_q;
   logic [1:0] cs_sync_q;
   logic [1:0] mosi_sync_q;
   logic       sclk_prev_q;
   logic [2:0] bit_cnt_q;
   logic [6:0] rx_shift_q;
   logic [6:0] tx_shift_q;
   logic       sclk_rise;
   logic       sclk_fall;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
   assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
   assign cs_active = ~cs_sync_q[1];
   // Strobe is combinational so the consumer can register the next byte early
   assign byte_done = sclk_rise & cs_active & (bit_cnt_q == 3'd7);
   assign rx_byte   = {rx_shift_q, mosi_sync_q[1]};

   // Two-flop synchronizers and SCLK history for edge detection
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sclk_sync_q <= 2'b00;
         cs_sync_q   <= 2'b11;
         mosi_sync_q <= 2'b11;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], SCLK};
         cs_sync_q   <= {cs_sync_q[0], CS};
         mosi_sync_q <= {mosi_sync_q[0], MOSI};
         sclk_prev_q <= sclk_sync_q[1];
      end
   end

   // Shift registers: sample on rise, drive next MISO bit on fall
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bit_cnt_q  <= 3'd0;
         rx_shift_q <= 7'd0;
         tx_shift_q <= 7'h7F;
         MISO       <= 1'b1;
      end else if (!cs_active) begin
         bit_cnt_q  <= 3'd0;
         rx_shift_q <= 7'd0;
         tx_shift_q <= 7'h7F;
         MISO       <= 1'b1;
      end else begin
         if (sclk_rise) begin
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            rx_shift_q <= {rx_shift_q[5:0], mosi_sync_q[1]};
         end
         if (sclk_fall) begin
            // Counter wrapped to 0: the previous byte is finished, start the next
            if (bit_cnt_q == 3'd0) begin
               MISO       <= tx_byte[7];
               tx_shift_q <= tx_byte[6:0];
            end else begin
               MISO       <= tx_shift_q[6];
               tx_shift_q <= {tx_shift_q[5:0], 1'b1};
            end
         end
      end
   end

endmodule

// File: rtl/sd_spi_responder.sv
// SD card SPI-mode command responder. Hunts for a command start byte, collects
// the 6-byte frame, publishes index/argument on CMD_STB/CMD_ACK, then answers
// with NCR filler bytes and an R1 byte. Tracks idle/app state for the
// CMD0 / CMD55 / ACMD41 initialisation handshake.
// Build option: define SD_RESP_CRC_CHECK_EN to check the CRC7 of each frame.
module sd_spi_responder
   import sd_spi_responder_pkg::*;
#(
   parameter int unsigned NCR        = 1,
   parameter int unsigned INIT_COUNT = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic        CS,
   output logic        MISO,
   output logic        CMD_STB,
   input  logic        CMD_ACK,
   output logic [5:0]  CMD_IDX,
   output logic [31:0] CMD_ARG
);

   logic        cs_active;
   logic        byte_done;
   logic [7:0]  rx_byte;
   logic [7:0]  tx_byte_q;

   resp_state_e state_q;
   logic [5:0]  frame_idx_q;
   logic [31:0] arg_shift_q;
   logic [2:0]  byte_cnt_q;
   logic [2:0]  ncr_cnt_q;
   logic [7:0]  r1_q;
   logic        idle_q;
   logic        app_q;
   logic [7:0]  acmd_cnt_q;

   logic        crc_err;
   logic        idle_d;
   logic        app_d;
   logic [7:0]  acmd_cnt_d;
   logic [7:0]  r1_d;

   spi_slave_byte u_spi (
      .CLK       (CLK),
      .RST       (RST),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .CS        (CS),
      .tx_byte   (tx_byte_q),
      .MISO      (MISO),
      .cs_active (cs_active),
      .byte_done (byte_done),
      .rx_byte   (rx_byte)
   );

   // Command decode: next flag state and R1, evaluated while the CRC byte arrives
   always_comb begin
      idle_d     = idle_q;
      app_d      = 1'b0;
      acmd_cnt_d = acmd_cnt_q;
      r1_d       = 8'h00;
      crc_err    = 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
      crc_err = (crc7({2'b01, frame_idx_q, arg_shift_q}) != rx_byte[7:1]);
`endif
      if (crc_err) begin
         app_d                = app_q;
         r1_d[R1_CRC_BIT]     = 1'b1;
      end else if (frame_idx_q == CMD0) begin
         idle_d     = 1'b1;
         acmd_cnt_d = 8'd0;
      end else if (frame_idx_q == CMD55) begin
         app_d = 1'b1;
      end else if (frame_idx_q == CMD41 && app_q) begin
         if (acmd_cnt_q != 8'hFF) begin
            acmd_cnt_d = acmd_cnt_q + 8'd1;
         end
         if (acmd_cnt_d == 8'(INIT_COUNT)) begin
            idle_d = 1'b0;
         end
      end else begin
         r1_d[R1_ILLEGAL_BIT] = 1'b1;
      end
      r1_d[R1_IDLE_BIT] = idle_d;
   end

   // Frame FSM with registered command outputs and response byte
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StHunt;
         frame_idx_q <= 6'd0;
         arg_shift_q <= 32'd0;
         byte_cnt_q  <= 3'd0;
         ncr_cnt_q   <= 3'd0;
         r1_q        <= 8'hFF;
         tx_byte_q   <= 8'hFF;
         idle_q      <= 1'b1;
         app_q       <= 1'b0;
         acmd_cnt_q  <= 8'd0;
         CMD_STB     <= 1'b0;
         CMD_IDX     <= 6'd0;
         CMD_ARG     <= 32'd0;
      end else begin
         if (CMD_ACK) begin
            CMD_STB <= 1'b0;
         end
         if (!cs_active) begin
            state_q    <= StHunt;
            tx_byte_q  <= 8'hFF;
            byte_cnt_q <= 3'd0;
            ncr_cnt_q  <= 3'd0;
         end else if (byte_done) begin
            unique case (state_q)
               StHunt: begin
                  if (rx_byte[7:6] == 2'b01) begin
                     frame_idx_q <= rx_byte[5:0];
                     byte_cnt_q  <= 3'd0;
                     state_q     <= StCollect;
                  end
               end
               StCollect: begin
                  if (byte_cnt_q == 3'd4) begin
                     // CRC byte: frame complete; a new frame overrides a pending one
                     CMD_IDX    <= frame_idx_q;
                     CMD_ARG    <= arg_shift_q;
                     CMD_STB    <= 1'b1;
                     idle_q     <= idle_d;
                     app_q      <= app_d;
                     acmd_cnt_q <= acmd_cnt_d;
                     r1_q       <= r1_d;
                     ncr_cnt_q  <= 3'd0;
                     state_q    <= StNcr;
                  end else begin
                     arg_shift_q <= {arg_shift_q[23:0], rx_byte};
                     byte_cnt_q  <= byte_cnt_q + 3'd1;
                  end
               end
               StNcr: begin
                  if (ncr_cnt_q == 3'(NCR - 1)) begin
                     tx_byte_q <= r1_q;
                     state_q   <= StR1;
                  end else begin
                     ncr_cnt_q <= ncr_cnt_q + 3'd1;
                  end
               end
               StR1: begin
                  tx_byte_q <= 8'hFF;
                  state_q   <= StHunt;
               end
               default: state_q <= StHunt;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: host-side SPI mode-0 driver, frames
// built with a bench-local CRC7, hand-computed R1 expectations.
module tb_sd_spi_responder;

   localparam int unsigned NCR        = 1;
   localparam int unsigned INIT_COUNT = 2;

   logic        CLK     = 1'b0;
   logic        RST     = 1'b1;
   logic        SCLK    = 1'b0;
   logic        MOSI    = 1'b1;
   logic        CS      = 1'b1;
   logic        CMD_ACK = 1'b0;
   logic        MISO;
   logic        CMD_STB;
   logic [5:0]  CMD_IDX;
   logic [31:0] CMD_ARG;

   int   errors    = 0;
   int   checks    = 0;
   int   stb_rises = 0;
   logic stb_d     = 1'b0;

   sd_spi_responder #(
      .NCR        (NCR),
      .INIT_COUNT (INIT_COUNT)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .CS      (CS),
      .MISO    (MISO),
      .CMD_STB (CMD_STB),
      .CMD_ACK (CMD_ACK),
      .CMD_IDX (CMD_IDX),
      .CMD_ARG (CMD_ARG)
   );

   always #5 CLK = ~CLK;

   // Count CMD_STB rising edges
   always @(posedge CLK) begin
      stb_d <= CMD_STB;
      if (CMD_STB && !stb_d) stb_rises <= stb_rises + 1;
   end

   function automatic logic [6:0] tb_crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       f;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         f = d[i] ^ c[6];
         c = {c[5:0], 1'b0};
         if (f) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] body;
      body = {2'b01, idx, arg};
      return {body, tb_crc7(body), 1'b1};
   endfunction

   function automatic logic [7:0] lead_byte(input int i);
      if (i % 3 == 0) return 8'h00;
      if (i % 3 == 1) return 8'hC0;
      return 8'hFF;
   endfunction

   // Host shifts n bits MSB first; MISO sampled just before each rising edge
   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - n; i--) begin
         MOSI = tx[i];
         #60;
         rx[i] = MISO;
         SCLK = 1'b1;
         #60;
         SCLK = 1'b0;
      end
   endtask

   // Full command transaction: lead junk bytes, 6 frame bytes, NCR fillers, R1
   task automatic xfer_cmd(input logic [47:0] frame, input int lead,
                           output logic [7:0] r1, output logic all_ff);
      logic [7:0] rx;
      CS     = 1'b0;
      all_ff = 1'b1;
      for (int i = 0; i < lead; i++) begin
         spi_bits(lead_byte(i), 8, rx);
         if (rx !== 8'hFF) all_ff = 1'b0;
      end
      for (int i = 0; i < 6; i++) begin
         spi_bits(frame[47 - 8 * i -: 8], 8, rx);
         if (rx !== 8'hFF) all_ff = 1'b0;
      end
      for (int i = 0; i < int'(NCR); i++) begin
         spi_bits(8'hFF, 8, rx);
         if (rx !== 8'hFF) all_ff = 1'b0;
      end
      spi_bits(8'hFF, 8, r1);
      #60;
      CS = 1'b1;
      #120;
   endtask

   task automatic do_ack();
      @(negedge CLK) CMD_ACK = 1'b1;
      @(negedge CLK) CMD_ACK = 1'b0;
   endtask

   task automatic test_reset();
      #25;
      checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b expected 1", MISO); end
      checks++; if (CMD_STB !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", CMD_STB); end
      checks++; if (CMD_IDX !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", CMD_IDX); end
      checks++; if (CMD_ARG !== 32'd0) begin errors++; $display("FAIL reset_arg: got %h expected 0", CMD_ARG); end
      @(negedge CLK) RST = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_cs_high();
      logic [7:0] rx;
      logic       all_one;
      int         rises0;
      rises0  = stb_rises;
      all_one = 1'b1;
      CS      = 1'b1;
      for (int b = 0; b < 10; b++) begin
         if (b == 0) spi_bits(8'h40, 8, rx);
         else        spi_bits(8'hFF, 8, rx);
         if (rx !== 8'hFF) all_one = 1'b0;
      end
      #120;
      checks++; if (all_one !== 1'b1) begin errors++; $display("FAIL cs_high_miso: got 0-bit expected all ones"); end
      checks++; if (stb_rises !== rises0) begin errors++; $display("FAIL cs_high_stb: got %0d rises expected 0", stb_rises - rises0); end
   endtask

   task automatic test_cmd0();
      logic [7:0] r1;
      logic       ff;
      xfer_cmd(48'h40_00_00_00_00_95, 0, r1, ff);
      checks++; if (ff !== 1'b1) begin errors++; $display("FAIL cmd0_filler: got non-FF byte expected FF"); end
      checks++; if (r1 !== 8'h01) begin errors++; $display("FAIL cmd0_r1: got %h expected 01", r1); end
      checks++; if (CMD_STB !== 1'b1) begin errors++; $display("FAIL cmd0_stb: got %b expected 1", CMD_STB); end
      checks++; if (CMD_IDX !== 6'd0) begin errors++; $display("FAIL cmd0_idx: got %0d expected 0", CMD_IDX); end
      checks++; if (CMD_ARG !== 32'd0) begin errors++; $display("FAIL cmd0_arg: got %h expected 0", CMD_ARG); end
      do_ack();
      checks++; if (CMD_STB !== 1'b0) begin errors++; $display("FAIL ack_drop: got %b expected 0", CMD_STB); end
   endtask

   task automatic test_crc();
      logic [7:0] r1;
      logic [7:0] exp_r1;
      logic       ff;
`ifdef SD_RESP_CRC_CHECK_EN
      exp_r1 = 8'h09;
`else
      exp_r1 = 8'h01;
`endif
      xfer_cmd(48'h40_00_00_00_00_00, 0, r1, ff);
      checks++; if (r1 !== exp_r1) begin errors++; $display("FAIL crc_r1: got %h expected %h", r1, exp_r1); end
      do_ack();
   endtask

   task automatic test_init();
      logic [5:0]  idxs [6] = '{6'd0, 6'd55, 6'd41, 6'd55, 6'd41, 6'd17};
      logic [31:0] args [6] = '{32'h0, 32'h0, 32'h4000_0000, 32'h0, 32'h4000_0000, 32'h1234_5678};
      logic [7:0]  exps [6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h04};
      int          leads [6] = '{0, 0, 3, 0, 2, 1};
      logic [7:0]  r1;
      logic        ff;
      for (int k = 0; k < 6; k++) begin
         xfer_cmd(mk_frame(idxs[k], args[k]), leads[k], r1, ff);
         checks++;
         if (r1 !== exps[k]) begin
            errors++; $display("FAIL init_r1[%0d]: got %h expected %h", k, r1, exps[k]);
         end
         do_ack();
      end
      checks++; if (CMD_IDX !== 6'd17) begin errors++; $display("FAIL cmd17_idx: got %0d expected 17", CMD_IDX); end
      checks++; if (CMD_ARG !== 32'h1234_5678) begin errors++; $display("FAIL cmd17_arg: got %h expected 12345678", CMD_ARG); end
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      logic [7:0] r1;
      logic       ff;
      int         rises0;
      rises0 = stb_rises;
      CS = 1'b0;
      spi_bits(8'h40, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 8, rx);
      #60;
      CS = 1'b1;
      #120;
      xfer_cmd(48'h40_00_00_00_00_95, 0, r1, ff);
      checks++; if (stb_rises - rises0 !== 1) begin errors++; $display("FAIL abort_stb_count: got %0d expected 1", stb_rises - rises0); end
      checks++; if (r1 !== 8'h01) begin errors++; $display("FAIL abort_r1: got %h expected 01", r1); end
      do_ack();
   endtask

   task automatic test_back_to_back();
      logic [7:0]  r1;
      logic [7:0]  rx;
      logic [47:0] fr;
      logic        ff;
      int          rises0;
      rises0 = stb_rises;
      xfer_cmd(mk_frame(6'd0, 32'h0), 0, r1, ff);
      xfer_cmd(mk_frame(6'd55, 32'h0), 0, r1, ff);
      checks++; if (CMD_STB !== 1'b1) begin errors++; $display("FAIL b2b_stb: got %b expected 1", CMD_STB); end
      checks++; if (CMD_IDX !== 6'd55) begin errors++; $display("FAIL b2b_idx: got %0d expected 55", CMD_IDX); end
      checks++; if (stb_rises - rises0 !== 1) begin errors++; $display("FAIL b2b_rises: got %0d expected 1", stb_rises - rises0); end
      // CMD0 again, stop three bits into R1 (0x01) and reset
      fr = mk_frame(6'd0, 32'h0);
      CS = 1'b0;
      for (int i = 0; i < 6; i++) spi_bits(fr[47 - 8 * i -: 8], 8, rx);
      for (int i = 0; i < int'(NCR); i++) spi_bits(8'hFF, 8, rx);
      spi_bits(8'hFF, 3, rx);
      #50;
      checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL mid_r1_miso: got %b expected 0", MISO); end
      RST = 1'b1;
      #1;
      checks++; if (MISO !== 1'b1) begin errors++; $display("FAIL rst_miso: got %b expected 1", MISO); end
      checks++; if (CMD_STB !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b expected 0", CMD_STB); end
      #9;
      CS  = 1'b1;
      RST = 1'b0;
      #40;
   endtask

   initial begin
      test_reset();
      test_cs_high();
      test_cmd0();
      test_crc();
      test_init();
      test_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 NCR, 1, number of 0xFF filler bytes the block shifts out between the last command byte and R1 (range 1..8).
REQ-002 INIT_COUNT, 2, number of ACMD41 commands needed to leave idle state (range 1..255).
REQ-003 CLK  in  1  system clock, at least 4x SCLK frequency.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 SCLK  in  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0).
REQ-006 MOSI  in  1  serial data from host, MSB first.
REQ-007 CS  in  1  chip select from host, active-low.
REQ-008 MISO  out  1  serial data to host, MSB first; never tristated.
REQ-009 CMD_STB  out  1  decoded-command valid, held high until CMD_ACK.
REQ-010 CMD_ACK  in  1  consumer acknowledge for CMD_STB.
REQ-011 CMD_IDX  out  6  command index of the last decoded frame.
REQ-012 CMD_ARG  out  32  argument of the last decoded frame, byte 1 in bits 31:24.

Function
REQ-013 SCLK, MOSI and CS SHALL each pass through a 2-flop synchronizer; SCLK edges SHALL be detected in the CLK domain.
REQ-014 MOSI SHALL be sampled on SCLK rising edge; MISO SHALL update on SCLK falling edge; the first MISO bit of a byte SHALL be valid before the first rising edge after the previous byte.
REQ-015 While CS high: bit/byte counters cleared, MISO=1, pending response discarded, no frame decoding.
REQ-016 Hunt state: with CS low, received bytes with bits 7:6 != 01 are ignored; a byte with bits 7:6 = 01 starts a frame (CMD_IDX candidate = bits 5:0).
REQ-017 Collect state: the next 5 bytes SHALL be taken as argument bytes 1..4 and CRC byte; MISO=1 throughout.
REQ-018 After byte 6: CMD_IDX/CMD_ARG SHALL update and CMD_STB SHALL rise within 2 CLK cycles; a new frame completing while CMD_STB is high overwrites CMD_IDX/CMD_ARG and CMD_STB remains high.
REQ-019 CMD_STB SHALL drop the cycle after CMD_ACK is sampled high; CMD_ACK with CMD_STB low is ignored.
REQ-020 Ncr state: NCR bytes of 0xFF SHALL be shifted out, then R1 state shifts out one R1 byte, then return to Hunt; bytes received during Ncr/R1 are not decoded.
REQ-021 R1 bit 0 = idle flag; bit 2 = illegal command; bit 3 = CRC error; other bits 0.
REQ-022 CMD0: idle flag set, app flag cleared, ACMD41 counter cleared; R1=0x01.
REQ-023 CMD55: app flag set; R1=idle flag.
REQ-024 CMD41 with app flag set: counter increments (saturating); when counter reaches INIT_COUNT idle flag clears; R1 = resulting idle flag.
REQ-025 Any other command, or CMD41 without app flag: R1 = 0x04 | idle flag.
REQ-026 App flag SHALL clear after any command other than CMD55.
REQ-027 CS rising mid-frame, mid-Ncr or mid-R1 SHALL abort to Hunt with no CMD_STB for an incomplete frame; already-raised CMD_STB is unaffected.

Reset
REQ-028 RST SHALL force MISO=1, CMD_STB=0, CMD_IDX=0, CMD_ARG=0, idle flag=1, app flag=0, ACMD41 counter=0, FSM=Hunt, synchronizers to idle values (SCLK=0, CS=1, MOSI=1).

Configuration
REQ-029 With SD_RESP_CRC_CHECK_EN defined: CRC7 (poly x^7+x^3+1, init 0) over bytes 1..5 compared to CRC byte bits 7:1; mismatch gives R1 = 0x08 | idle flag, no state change, CMD_STB still raised.
REQ-030 Without SD_RESP_CRC_CHECK_EN: CRC byte ignored, no CRC logic synthesized, R1 bit 3 always 0.

Structure
REQ-031 Shared package SHALL hold command index constants (CMD0, CMD41, CMD55), R1 bit positions and the CRC7 polynomial constant.
REQ-032 One sub-module spi_slave_byte SHALL contain the synchronizers, edge detect and 8-bit shift in/out with byte-done strobe and load interface.

Verification
REQ-033 CS low, host sends 40 00 00 00 00 95 then 2x FF -> MISO bytes FF..FF, FF, 01; CMD_STB with CMD_IDX=0, CMD_ARG=0.
REQ-034 CS high, 10 bytes FF clocked -> MISO constant 1, CMD_STB never rises.
REQ-035 CMD0 with CRC byte 00 -> R1=0x09 with SD_RESP_CRC_CHECK_EN, 0x01 without.
REQ-036 After CMD0: CMD55, ACMD41, CMD55, ACMD41 (INIT_COUNT=2) -> R1 sequence 01, 01, 01, 00; then CMD17 -> 04.
REQ-037 CS raised after 3 bytes of CMD0, lowered, full CMD0 sent -> exactly one CMD_STB, R1=0x01.
REQ-038 CMD_ACK held low across two frames (CMD0 then CMD55) -> CMD_STB stays high, CMD_IDX=55; RST asserted mid-R1 -> MISO=1, CMD_STB=0 immediately.
